// File: rtl/i281_pkg.sv
// Shared i281 definitions: data-memory owner encoding and default bus widths.
package i281_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-ported i281 data memory between the CPU datapath and a host loader port.
// CPU has priority; a wait counter bounds host starvation and host_lock allows bounded bursts.
module dmem_arbiter
  import i281_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int HOST_WAIT_MAX  = 3,
  parameter int HOST_MAX_BURST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int WAIT_W  = $clog2(HOST_WAIT_MAX + 1);
  localparam int BURST_W = $clog2(HOST_MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(HOST_WAIT_MAX);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(HOST_MAX_BURST);

  owner_t              state_q;
  owner_t              state_d;
  logic                c_el;
  logic                h_el;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [BURST_W-1:0]  burst_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An owner never re-wins at the edge closing its own grant, except a locked host burst.
  always_comb begin
    c_el    = cpu_req & run & (state_q != CPU);
    h_el    = host_req & ((state_q != HOST) | (host_lock & (burst_cnt < BURST_LIMIT)));
    state_d = IDLE;
    if (h_el & ((state_q == HOST) | (wait_cnt == WAIT_LIMIT))) begin
      state_d = HOST;
    end else if (c_el) begin
      state_d = CPU;
    end else if (h_el) begin
      state_d = HOST;
    end
  end

  always_comb begin
    cpu_gnt   = (state_q == CPU);
    host_gnt  = (state_q == HOST);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      HOST: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: begin
      end
    endcase
  end

  assign owner = state_q;

  // Stall is held low while in reset so every output reads zero there.
  assign cpu_stall = reset & cpu_req & run & ~cpu_gnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if ((state_d == HOST) || !host_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (state_d == HOST) begin
        burst_cnt <= (state_q == HOST) ? burst_cnt + BURST_W'(1) : BURST_W'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      cpu_rvalid  <= (state_q == CPU) & ~cpu_we;
      host_rvalid <= (state_q == HOST) & ~host_we;
      if ((state_q == CPU) && !cpu_we) begin
        cpu_rdata <= mem_rdata;
      end
      if ((state_q == HOST) && !host_we) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word memory model on the arbitrated bus.
module tb_dmem_arbiter;

  logic       clock;
  logic       reset;
  logic       run;
  logic       cpu_req, cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt, cpu_rvalid, cpu_stall;
  logic [7:0] cpu_rdata;
  logic       host_req, host_we, host_lock;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [1:0] owner;

  logic       preload;
  logic [7:0] mem [16];

  int vectors    = 0;
  int miscompares = 0;

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_lock  (host_lock),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .owner      (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Preload pattern: word i holds 8'h11*i, except word 2 which holds 8'h3C.
  function automatic logic [7:0] init_val(input int i);
    return (i == 2) ? 8'h3C : 8'(i * 17);
  endfunction

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] rd_addr [3];
    logic [7:0] rd_data [3];
    int  b;
    logic prev_host;
    logic exp_host;

    rd_addr = '{4'd7, 4'd3, 4'd9};
    rd_data = '{8'h77, 8'h33, 8'h99};

    run = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_lock = 0; host_addr = 0; host_wdata = 0;
    preload = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_output("rst_owner", 32'(owner), 32'd0);
    check_output("rst_gnts", {30'd0, cpu_gnt, host_gnt}, 32'd0);
    check_output("rst_rvalid", {30'd0, cpu_rvalid, host_rvalid}, 32'd0);
    check_output("rst_rdata", {16'd0, cpu_rdata, host_rdata}, 32'd0);
    check_output("rst_mem", {19'd0, mem_we, mem_addr, mem_wdata}, 32'd0);

    // Reset arriving mid host write grant must abort the write.
    tick;
    preload = 1'b0;
    reset = 1'b1;
    host_req = 1; host_we = 1; host_addr = 4'd5; host_wdata = 8'hA5;
    tick;
    #1;
    check_output("hw_gnt", 32'(host_gnt), 32'd1);
    check_output("hw_we", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check_output("abort_we", 32'(mem_we), 32'd0);
    check_output("abort_gnt", 32'(host_gnt), 32'd0);
    check_output("abort_owner", 32'(owner), 32'd0);
    check_output("abort_bus", {4'd0, mem_addr, mem_wdata}, 32'd0);
    tick;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    tick;
    reset = 1'b1;
    @(negedge clock);
    check_output("abort_mem5", 32'(mem[5]), 32'h55);

    // Simultaneous requests from IDLE: CPU first, host next cycle.
    tick;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd2;
    host_req = 1; host_we = 0; host_addr = 4'd7;
    tick;
    @(negedge clock);
    check_output("sim_c1_owner", 32'(owner), 32'd1);
    check_output("sim_c1_gnts", {30'd0, cpu_gnt, host_gnt}, 32'b10);
    check_output("sim_c1_addr", 32'(mem_addr), 32'd2);
    tick;
    cpu_req = 0;
    @(negedge clock);
    check_output("sim_c2_owner", 32'(owner), 32'd2);
    check_output("sim_c2_addr", 32'(mem_addr), 32'd7);
    check_output("sim_c2_crvalid", 32'(cpu_rvalid), 32'd1);
    check_output("sim_c2_crdata", 32'(cpu_rdata), 32'h3C);
    tick;
    host_req = 0;
    @(negedge clock);
    check_output("sim_c3_owner", 32'(owner), 32'd0);
    check_output("sim_c3_hrvalid", 32'(host_rvalid), 32'd1);
    check_output("sim_c3_hrdata", 32'(host_rdata), 32'h77);
    check_output("sim_c3_crvalid", 32'(cpu_rvalid), 32'd0);

    // run low: CPU ignored, unlocked host reads alternate grant/idle.
    tick;
    run = 0; cpu_req = 1; cpu_addr = 4'd1;
    host_req = 1; host_we = 0; host_addr = rd_addr[0];
    for (int k = 0; k < 6; k++) begin
      tick;
      if (k % 2 == 1) begin
        if (k == 5) host_req = 0;
        else host_addr = rd_addr[(k + 1) / 2];
      end
      @(negedge clock);
      check_output($sformatf("run0_owner%0d", k), 32'(owner), (k % 2 == 0) ? 32'd2 : 32'd0);
      check_output($sformatf("run0_cgnt_stall%0d", k), {30'd0, cpu_gnt, cpu_stall}, 32'd0);
      if (k % 2 == 0) begin
        check_output($sformatf("run0_addr%0d", k), 32'(mem_addr), 32'(rd_addr[k / 2]));
      end else begin
        check_output($sformatf("run0_rvalid%0d", k), 32'(host_rvalid), 32'd1);
        check_output($sformatf("run0_rdata%0d", k), 32'(host_rdata), 32'(rd_data[k / 2]));
      end
    end
    tick;
    cpu_req = 0; run = 1;

    // CPU held with fresh accesses, host write held: grants interleave.
    tick;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd2;
    host_req = 1; host_we = 1; host_addr = 4'd13; host_wdata = 8'h6B;
    tick;
    @(negedge clock);
    check_output("stv_c1_owner", 32'(owner), 32'd1);
    check_output("stv_c1_we", 32'(mem_we), 32'd0);
    check_output("stv_c1_stall", 32'(cpu_stall), 32'd0);
    tick;
    cpu_we = 1; cpu_addr = 4'd12; cpu_wdata = 8'h5A;
    @(negedge clock);
    check_output("stv_c2_owner", 32'(owner), 32'd2);
    check_output("stv_c2_bus", {19'd0, mem_we, mem_addr, mem_wdata}, {19'd0, 1'b1, 4'd13, 8'h6B});
    check_output("stv_c2_crdata", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'h3C});
    check_output("stv_c2_stall", 32'(cpu_stall), 32'd1);
    tick;
    @(negedge clock);
    check_output("stv_c3_owner", 32'(owner), 32'd1);
    check_output("stv_c3_bus", {19'd0, mem_we, mem_addr, mem_wdata}, {19'd0, 1'b1, 4'd12, 8'h5A});
    check_output("stv_c3_hrvalid", 32'(host_rvalid), 32'd0);
    tick;
    cpu_req = 0; cpu_we = 0;
    @(negedge clock);
    check_output("stv_c4_owner", 32'(owner), 32'd2);
    check_output("stv_c4_crdata", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b0, 8'h3C});
    tick;
    host_req = 0; host_we = 0;
    @(negedge clock);
    check_output("stv_c5_owner", 32'(owner), 32'd0);
    check_output("stv_mem12", 32'(mem[12]), 32'h5A);
    check_output("stv_mem13", 32'(mem[13]), 32'h6B);

    // Locked host burst of 20 writes with a CPU read pending from the 2nd beat.
    tick;
    b = 0;
    host_req = 1; host_we = 1; host_lock = 1; host_addr = 4'd0; host_wdata = 8'hC0;
    cpu_we = 0; cpu_addr = 4'd0;
    prev_host = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick;
      if (prev_host) begin
        b++;
        if (b < 20) begin
          host_addr  = 4'(b);
          host_wdata = 8'(8'hC0 + b);
        end else begin
          host_req = 0; host_we = 0;
        end
        if (b == 19) host_lock = 0;
      end
      if (c == 2) cpu_req = 1;
      if (c == 18) cpu_req = 0;
      @(negedge clock);
      exp_host = (c != 17) && (c != 22);
      check_output($sformatf("bst_owner%0d", c), 32'(owner),
                   exp_host ? 32'd2 : ((c == 17) ? 32'd1 : 32'd0));
      if (exp_host) begin
        check_output($sformatf("bst_bus%0d", c), {19'd0, mem_we, mem_addr, mem_wdata},
                     {19'd0, 1'b1, 4'(b), 8'(8'hC0 + b)});
      end
      if (c == 5) check_output("bst_stall", 32'(cpu_stall), 32'd1);
      if (c == 18) check_output("bst_crdata", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'hC0});
      prev_host = exp_host;
    end
    check_output("bst_mem0", 32'(mem[0]), 32'hD0);
    check_output("bst_mem3", 32'(mem[3]), 32'hD3);
    check_output("bst_mem4", 32'(mem[4]), 32'hC4);
    check_output("bst_mem15", 32'(mem[15]), 32'hCF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported i281 data memory between the CPU datapath (control-FSM driven load/store) and an external host port (program/data loader, debugger). Grants one memory access per cycle, prioritises the CPU with a bounded host-starvation guard, and supports locked host bursts for bulk loading. It sits between the datapath's data-memory address/data wiring and the datamem instance.

## Interface
- ADDR_W, 4, data memory address width
- DATA_W, 8, data word width
- HOST_WAIT_MAX, 3, cycles a pending host request may lose to the CPU before it is forced to win (≥1)
- HOST_MAX_BURST, 16, maximum back-to-back host grants under host_lock (≥1)

- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  CPU enable; when low, CPU requests are ignored and the host is still served
- cpu_req / cpu_we  in  1 / 1  CPU access request, write enable
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address, write data
- cpu_gnt  out  1  high during the CPU's access cycle
- cpu_rvalid / cpu_rdata  out  1 / DATA_W  read-return pulse, captured read data
- cpu_stall  out  1  cpu_req & run & ~cpu_gnt (combinational)
- host_req / host_we / host_lock  in  1 each  host request, write enable, burst lock
- host_addr / host_wdata  in  ADDR_W / DATA_W  host address, write data
- host_gnt  out  1  high during the host's access cycle
- host_rvalid / host_rdata  out  1 / DATA_W  read-return pulse, captured read data
- mem_we  out  1  data memory write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  data memory address, write data
- mem_rdata  in  DATA_W  data memory asynchronous read data
- owner  out  2  current state: 0 IDLE, 1 CPU, 2 HOST

## Operation
- States are IDLE, CPU, and HOST. The state register is the grant: cpu_gnt = (state==CPU) and host_gnt = (state==HOST).
- In CPU/HOST, mem_addr, mem_wdata and mem_we come from the owner's inputs. In IDLE they are all 0.
- The access completes at the rising edge that ends the grant cycle. The requester holds req/addr/we/wdata stable until that edge.
- Eligibility at each edge:
  - c_el = cpu_req & run & (state≠CPU).
  - h_el = host_req & (state≠HOST | (host_lock & burst_cnt<HOST_MAX_BURST)).
  - A requester's own req is masked at the edge closing its grant, so each requester gets at most one access per 2 cycles. The exception is a locked host burst.
- Next-state priority:
  1. HOST, if h_el & (state==HOST | wait_cnt==HOST_WAIT_MAX).
  2. Else CPU, if c_el.
  3. Else HOST, if h_el.
  4. Else IDLE.
- wait_cnt:
  - Cleared when next state is HOST or host_req is low.
  - Otherwise increments, saturating at HOST_WAIT_MAX.
- burst_cnt:
  - Set to 1 on entry to HOST.
  - Increments on each consecutive HOST→HOST edge.
  - Cleared otherwise.
  - Reaching HOST_MAX_BURST forces at least one non-HOST cycle.
- Read return:
  - At the edge ending a read grant (we=0), mem_rdata is captured into the owner's rdata register.
  - The owner's rvalid is high for exactly the following cycle.
  - rdata holds its value until that port's next read. Writes never change rdata.
- run falling while in state CPU: the in-progress CPU access still completes. No new CPU grant is made while run is low.

## Timing
- Reset (asynchronous, active-low):
  - State goes to IDLE and all counters to 0.
  - Every output is 0, including rdata and rvalid.
  - An in-flight access is aborted and no write occurs.
- Request-to-grant latency: minimum 1 cycle (request seen at edge N, gnt high in cycle N+1).
- Read data latency: rvalid/rdata valid 1 cycle after the grant cycle.
- Worst-case host wait with cpu_req held continuously: HOST_WAIT_MAX+1 cycles.
- Worst-case CPU wait during a locked burst: HOST_MAX_BURST+1 cycles.
- Simultaneous cpu_req and host_req from IDLE with wait_cnt<HOST_WAIT_MAX: CPU wins.
- Host switching from write to read inside a burst is legal. Each beat uses that cycle's host_we.
- Address wrap-around is not handled here. Addresses pass through unmodified.

## Structure
- A shared package i281_pkg holds the owner_t state enum (IDLE=0, CPU=1, HOST=2) and the default ADDR_W/DATA_W constants.
- Single module; no sub-module is warranted. Counters, next-state logic and the two capture registers are small.

## Test plan
- Reset during a host write grant (host_addr=5, wdata=8'hA5): mem_we drops immediately, all outputs 0, memory[5] unchanged.
- cpu_req and host_req asserted together from IDLE, CPU read addr 2 (mem=8'h3C):
  - cpu_gnt in cycle 1, host_gnt in cycle 2.
  - cpu_rvalid with 8'h3C in cycle 2.
- HOST_WAIT_MAX=3, cpu_req held high with a new address each grant, host_req held:
  - Host is granted no later than the 4th cycle after its request.
  - wait_cnt is then cleared.
- host_lock=1, host_req held for 20 writes, HOST_MAX_BURST=16, cpu_req pending:
  - 16 consecutive host_gnt cycles, then cpu_gnt for 1 cycle, then the host resumes.
  - memory contents match.
- run=0 with cpu_req=1: cpu_gnt never asserts, cpu_stall stays 0, host reads addr 7 normally.
- Back-to-back non-locked host reads: host_gnt alternates high/low. host_rvalid pulses follow each grant with correct data.
